median_sched: RTL and testbench
===============================

# median_sched

Round-robin scheduler that shares one MEDIAN engine (9-sample median filter) between NREQ clients. Grants one client at a time, streams that client's 9 samples into the engine, waits for the engine's done flag and returns the median tagged with the client index. A watchdog recovers the engine by resetting it if it never finishes. Sits between the per-channel sample producers and the single MEDIAN instance.

## Interface
- SIZE, 8, sample and result width in bits (matches MEDIAN SIZE)
- NREQ, 4, number of clients, ≥2; IDW = $clog2(NREQ)
- TMO, 64, watchdog limit in WAIT cycles, ≥48
- Fixed: samples per operation = 9 (MEDIAN LENGHT)

- CLK  in  1  clock; everything on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  NREQ  per-client request level; sampled only in IDLE
- DIN  in  NREQ*SIZE  client sample lanes; lane i = DIN[i*SIZE +: SIZE]
- GNT  out  NREQ  one-hot grant, registered, held from LOAD through DONE
- LD  out  1  load strobe; granted client advances its sample after each cycle with LD=1
- BUSY  out  1  state ≠ IDLE
- RES  out  SIZE  median result, registered, holds last value
- RES_ID  out  IDW  client index of RES
- RES_VAL  out  1  one-cycle result strobe
- ERR  out  1  one-cycle watchdog-expiry strobe
- MED_DI  out  SIZE  to MEDIAN DI; combinational mux of the granted lane, 0 when no grant
- MED_DSI  out  1  to MEDIAN DSI; equals LD
- MED_NRST  out  1  to MEDIAN nRST (active-low); low during RST and during FLUSH
- MED_DO  in  SIZE  from MEDIAN DO
- MED_DSO  in  1  from MEDIAN DSO (level, high while result valid)

## Operation
- States: IDLE, LOAD, WAIT, DONE, FLUSH. Counters: lcnt (0..8), wcnt (0..TMO-1), last pointer (IDW bits).
- IDLE: if any REQ, winner = first set bit scanning last+1, last+2, … modulo NREQ. Next cycle: GNT = onehot(winner), last = winner, lcnt = 0, state LOAD. No REQ: stay.
- LOAD: LD = MED_DSI = 1; MED_DI = DIN lane of winner. lcnt increments each cycle; at lcnt = 8 go WAIT with wcnt = 0. Exactly 9 LD cycles per operation.
- WAIT: LD = 0; wcnt increments. MED_DSO ignored while wcnt = 0 (stale flag from previous op; MEDIAN clears it one cycle after DSI toggles). If wcnt ≥ 1 and MED_DSO = 1: RES ← MED_DO, RES_ID ← winner, go DONE. Else if wcnt = TMO-1: go FLUSH.
- DONE (1 cycle): RES_VAL = 1, GNT still asserted; then GNT ← 0, state IDLE.
- FLUSH (1 cycle): ERR = 1, MED_NRST = 0, RES unchanged; then GNT ← 0, state IDLE.
- REQ changes outside IDLE are ignored; a client dropping REQ mid-operation still gets its result. A client is served again only if REQ is high when IDLE next samples it.
- Round-robin: with all REQ high, service order 0,1,2,3,0,… No client waits more than NREQ-1 operations.
- Arithmetic: lcnt 4 bits, wcnt $clog2(TMO) bits, never wrap (state exits first). last wraps NREQ-1 → 0.

## Timing
- Reset (RST=1 at an edge): state IDLE, GNT=0, LD=MED_DSI=0, BUSY=0, RES=0, RES_ID=0, RES_VAL=0, ERR=0, last=NREQ-1 (client 0 first), MED_NRST=0 while RST=1. RST mid-operation aborts immediately; no RES_VAL/ERR emitted.
- REQ high in IDLE cycle t → GNT and LD high from t+1 to t+9 (LD), BUSY from t+1.
- First cycle with MED_DSO=1 at wcnt≥1, cycle u → RES/RES_ID valid and RES_VAL=1 in u+1; GNT low and BUSY low in u+2; next grant earliest u+3.
- Back-to-back: one IDLE cycle between operations minimum.
- Watchdog: ERR and MED_NRST=0 exactly TMO cycles after the last LD cycle; IDLE next cycle.

## Test plan
- Single client: REQ[0]=1, lane 0 streams 9,1,8,2,7,3,6,4,5 with real MEDIAN → exactly 9 LD cycles, RES=5, RES_ID=0, RES_VAL one cycle, GNT low the cycle after.
- Round-robin: REQ=4'b1111 held, each lane streams constant 10*(i+1) → RES_ID sequence 0,1,2,3,0; RES = 10,20,30,40,10.
- Fairness after reset: REQ=4'b1010 → first grant client 1, then 3, then 1.
- Watchdog: MED_DSO stubbed 0 → ERR pulse and MED_NRST low exactly TMO=64 cycles after last LD, RES unchanged, then IDLE and next REQ granted.
- Stale DSO: stub holds MED_DSO=1 through first WAIT cycle then 0 until 20 cycles, MED_DO=0x33 → RES=0x33 captured at wcnt=20, not at wcnt=0.
- Reset mid-LOAD (after 4 LD cycles) → all outputs at reset values next cycle, no RES_VAL/ERR; REQ[2] afterwards → client 2 served correctly (RES = median of its 9 samples).

Source files
------------

// File: rtl/median_sched.sv
// Round-robin scheduler sharing one 9-sample MEDIAN engine between NREQ clients.
// Streams the granted client's samples, waits for the engine and returns a tagged result.
module median_sched #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 64,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*SIZE-1:0] DIN,
  output logic [NREQ-1:0]      GNT,
  output logic                 LD,
  output logic                 BUSY,
  output logic [SIZE-1:0]      RES,
  output logic [IDW-1:0]       RES_ID,
  output logic                 RES_VAL,
  output logic                 ERR,
  output logic [SIZE-1:0]      MED_DI,
  output logic                 MED_DSI,
  output logic                 MED_NRST,
  input  logic [SIZE-1:0]      MED_DO,
  input  logic                 MED_DSO
);

  localparam int unsigned WW = $clog2(TMO);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StDone, StFlush} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [3:0]      lcnt_q, lcnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [SIZE-1:0] res_q, res_d;
  logic [IDW-1:0]  res_id_q, res_id_d;

  logic            pick_found;
  logic [IDW-1:0]  pick_id;

  // Scan last+1, last+2, ... so the most recently served client comes last.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    lcnt_d   = lcnt_q;
    wcnt_d   = wcnt_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StLoad;
          gnt_d   = NREQ'(1) << pick_id;
          last_d  = pick_id;
          lcnt_d  = '0;
        end
      end
      StLoad: begin
        if (lcnt_q == 4'd8) begin
          state_d = StWait;
          wcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 4'd1;
        end
      end
      StWait: begin
        // DSO during the first WAIT cycle is left over from the previous operation.
        if (wcnt_q != '0 && MED_DSO) begin
          res_d    = MED_DO;
          res_id_d = last_q;
          state_d  = StDone;
        end else if (wcnt_q == WW'(TMO - 1)) begin
          state_d = StFlush;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      StDone, StFlush: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      last_q   <= IDW'(NREQ - 1);
      lcnt_q   <= '0;
      wcnt_q   <= '0;
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      lcnt_q   <= lcnt_d;
      wcnt_q   <= wcnt_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  always_comb begin
    MED_DI = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        MED_DI = DIN[i*SIZE +: SIZE];
      end
    end
  end

  assign GNT      = gnt_q;
  assign LD       = (state_q == StLoad);
  assign MED_DSI  = LD;
  assign BUSY     = (state_q != StIdle);
  assign RES      = res_q;
  assign RES_ID   = res_id_q;
  assign RES_VAL  = (state_q == StDone);
  assign ERR      = (state_q == StFlush);
  assign MED_NRST = ~(RST | (state_q == StFlush));

endmodule

// File: tb/tb_median_sched.sv
// Directed bench for median_sched with a behavioural MEDIAN engine and per-lane sample producers.
module tb_median_sched;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = 4'b0;
  logic [31:0] DIN;
  logic [3:0]  GNT;
  logic        LD, BUSY, RES_VAL, ERR, MED_DSI, MED_NRST, MED_DSO;
  logic [7:0]  RES, MED_DI, MED_DO;
  logic [1:0]  RES_ID;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;  // 0: engine model, 1: DSO stuck low, 2: stale-then-late DSO

  median_sched #(.SIZE(SIZE), .NREQ(NREQ), .TMO(TMO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN), .GNT(GNT), .LD(LD), .BUSY(BUSY),
    .RES(RES), .RES_ID(RES_ID), .RES_VAL(RES_VAL), .ERR(ERR), .MED_DI(MED_DI),
    .MED_DSI(MED_DSI), .MED_NRST(MED_NRST), .MED_DO(MED_DO), .MED_DSO(MED_DSO)
  );

  always #5 CLK = ~CLK;

  // Sample producers: each lane advances after a granted LD cycle, restarts when idle.
  logic [7:0] samp [4][9];
  int         idx  [4];
  always @(posedge CLK)
    for (int i = 0; i < 4; i++)
      if (!BUSY) idx[i] <= 0;
      else if (LD && GNT[i]) idx[i] <= idx[i] + 1;
  always_comb
    for (int i = 0; i < 4; i++) DIN[i*8 +: 8] = (idx[i] < 9) ? samp[i][idx[i]] : 8'h00;

  // Behavioural MEDIAN: collects 9 samples, raises DSO a few cycles after DSI falls.
  function automatic logic [7:0] med9(input logic [71:0] v);
    logic [7:0] t [9];
    logic [7:0] x;
    for (int i = 0; i < 9; i++) t[i] = v[i*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (t[j] > t[j+1]) begin x = t[j]; t[j] = t[j+1]; t[j+1] = x; end
    return t[4];
  endfunction

  logic [71:0] winv;
  int          mcnt = 0, mlat = 0, wc = 0;
  logic        armed = 1'b0, m_dso = 1'b0;
  logic [7:0]  m_do = 8'h00;
  always @(posedge CLK) begin
    if (!MED_NRST) begin
      mcnt <= 0; mlat <= 0; armed <= 1'b0; m_dso <= 1'b0; m_do <= 8'h00;
    end else if (MED_DSI) begin
      winv[mcnt*8 +: 8] <= MED_DI;
      mcnt  <= mcnt + 1;
      m_dso <= 1'b0;
      mlat  <= 0;
      if (mcnt == 8) armed <= 1'b1;
    end else if (armed) begin
      if (mlat == 5) begin
        m_dso <= 1'b1; m_do <= med9(winv); armed <= 1'b0; mcnt <= 0;
      end else mlat <= mlat + 1;
    end
  end

  // wc equals the DUT's WAIT counter during WAIT.
  always @(posedge CLK)
    if (LD) wc <= 0;
    else if (BUSY) wc <= wc + 1;

  assign MED_DSO = (mode == 0) ? m_dso : (mode == 1) ? 1'b0 : (wc == 0 || wc >= 20);
  assign MED_DO  = (mode == 2) ? 8'h33 : m_do;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Runs one operation from the grant edge until BUSY drops, collecting what happened.
  task automatic wait_op(output int ld_n, output int rv_n, output int err_n,
                         output int ld_last, output int rv_at, output int err_at,
                         output logic [3:0] gnt_first, output logic nrst_err,
                         output logic gnt_low_after, output logic [7:0] r,
                         output logic [1:0] rid, output logic tmo);
    logic prev_rv;
    ld_n = 0; rv_n = 0; err_n = 0; ld_last = 0; rv_at = 0; err_at = 0;
    nrst_err = 1'b1; gnt_low_after = 1'b0; r = 8'h00; rid = 2'd0; prev_rv = 1'b0;
    gnt_first = 4'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (c == 1) gnt_first = GNT;
      if (LD) begin ld_n++; ld_last = c; end
      if (RES_VAL) begin rv_n++; rv_at = c; r = RES; rid = RES_ID; end
      if (ERR) begin err_n++; err_at = c; nrst_err = MED_NRST; end
      if (prev_rv) gnt_low_after = (GNT == 4'b0);
      prev_rv = RES_VAL;
      if (!BUSY) break;
    end
    tmo = BUSY;
  endtask

  int         ld_n, rv_n, err_n, ld_last, rv_at, err_at;
  logic [3:0] gf;
  logic       nrst_err, gla, tmo;
  logic [7:0] r;
  logic [1:0] rid;

  task automatic test_reset;
    RST = 1'b1; tick(); tick();
    n_tests++; if (GNT !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
    n_tests++; if ({LD, MED_DSI, BUSY, RES_VAL, ERR} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {LD, MED_DSI, BUSY, RES_VAL, ERR}); end
    n_tests++; if ({RES, RES_ID} !== 10'h0) begin n_fail++; $display("FAIL reset_res: got %h/%0d want 0/0", RES, RES_ID); end
    n_tests++; if (MED_NRST !== 1'b0) begin n_fail++; $display("FAIL reset_nrst: got %b want 0", MED_NRST); end
    RST = 1'b0; tick();
  endtask

  task automatic test_single;
    logic [7:0] v [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    for (int k = 0; k < 9; k++) samp[0][k] = v[k];
    REQ = 4'b0001;
    wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
    REQ = 4'b0000;
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout: busy=%b want 0", tmo); end
    n_tests++; if (gf !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gf); end
    n_tests++; if (ld_n != 9) begin n_fail++; $display("FAIL single_ld_count: got %0d want 9", ld_n); end
    n_tests++; if (r !== 8'd5 || rid !== 2'd0) begin n_fail++; $display("FAIL single_res: got %0d/%0d want 5/0", r, rid); end
    n_tests++; if (rv_n != 1 || err_n != 0) begin n_fail++; $display("FAIL single_strobes: rv=%0d err=%0d want 1/0", rv_n, err_n); end
    n_tests++; if (gla !== 1'b1) begin n_fail++; $display("FAIL single_gnt_drop: got %b want 1", gla); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_id [5] = '{0, 1, 2, 3, 0};
    RST = 1'b1; tick(); RST = 1'b0;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 9; k++) samp[i][k] = 8'(10 * (i + 1));
    REQ = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
      n_tests++; if (rid !== exp_id[n] || r !== 8'(10 * (exp_id[n] + 1)) || rv_n != 1) begin
        n_fail++; $display("FAIL rr_op%0d: got id %0d res %0d want id %0d res %0d", n, rid, r, exp_id[n], 10 * (exp_id[n] + 1)); end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_fairness;
    logic [1:0] exp_id [3] = '{1, 3, 1};
    RST = 1'b1; tick(); RST = 1'b0;
    REQ = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
      n_tests++; if (rid !== exp_id[n] || gf !== (4'b0001 << exp_id[n])) begin
        n_fail++; $display("FAIL fair_op%0d: got id %0d gnt %b want id %0d", n, rid, gf, exp_id[n]); end
    end
    REQ = 4'b0000;
  endtask

  task automatic test_watchdog;
    mode = 1;
    REQ  = 4'b0001;
    wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
    REQ  = 4'b0000;
    mode = 0;
    n_tests++; if (gf !== 4'b0001 || err_n != 1 || rv_n != 0) begin
      n_fail++; $display("FAIL wd_strobes: gnt %b err %0d rv %0d want 0001/1/0", gf, err_n, rv_n); end
    // TMO WAIT cycles separate the last LD cycle from the FLUSH cycle.
    n_tests++; if (err_at - ld_last != TMO + 1) begin
      n_fail++; $display("FAIL wd_timing: got %0d want %0d", err_at - ld_last, TMO + 1); end
    n_tests++; if (nrst_err !== 1'b0) begin n_fail++; $display("FAIL wd_nrst: got %b want 0", nrst_err); end
    n_tests++; if (RES !== 8'd20 || RES_ID !== 2'd1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL wd_res_hold: got %0d/%0d busy %b want 20/1/0", RES, RES_ID, BUSY); end
    REQ = 4'b0100;
    wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
    REQ = 4'b0000;
    n_tests++; if (r !== 8'd30 || rid !== 2'd2 || rv_n != 1) begin
      n_fail++; $display("FAIL wd_recover: got %0d/%0d want 30/2", r, rid); end
  endtask

  task automatic test_stale_dso;
    mode = 2;
    REQ  = 4'b0010;
    wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
    REQ  = 4'b0000;
    mode = 0;
    n_tests++; if (r !== 8'h33 || rid !== 2'd1 || rv_n != 1) begin
      n_fail++; $display("FAIL stale_res: got %h/%0d want 33/1", r, rid); end
    n_tests++; if (rv_at - ld_last != 22) begin
      n_fail++; $display("FAIL stale_timing: got %0d want 22", rv_at - ld_last); end
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] v [9] = '{50, 20, 90, 10, 70, 30, 80, 40, 60};
    for (int k = 0; k < 9; k++) samp[2][k] = v[k];
    REQ = 4'b0001;
    tick(); tick(); tick(); tick();
    n_tests++; if (LD !== 1'b1 || GNT !== 4'b0001) begin
      n_fail++; $display("FAIL mid_loading: got ld %b gnt %b want 1/0001", LD, GNT); end
    REQ = 4'b0000; RST = 1'b1; tick();
    n_tests++; if ({GNT, LD, BUSY, RES_VAL, ERR} !== 8'b0 || {RES, RES_ID} !== 10'h0) begin
      n_fail++; $display("FAIL mid_reset: got gnt %b flags %b res %h want all 0", GNT, {LD, BUSY, RES_VAL, ERR}, RES); end
    RST = 1'b0; tick();
    n_tests++; if (RES_VAL !== 1'b0 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_strobe: got %b%b want 00", RES_VAL, ERR); end
    REQ = 4'b0100;
    wait_op(ld_n, rv_n, err_n, ld_last, rv_at, err_at, gf, nrst_err, gla, r, rid, tmo);
    REQ = 4'b0000;
    n_tests++; if (r !== 8'd50 || rid !== 2'd2 || ld_n != 9 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got %0d/%0d ld %0d want 50/2 ld 9", r, rid, ld_n); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) for (int k = 0; k < 9; k++) samp[i][k] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_watchdog();
    test_stale_dso();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
